// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack CPU field positions, widths and jump codes
//
// Purpose: common definitions for the Hack CPU register/PC stage and the
// later fetch unit.
// Contents: instruction field bit positions, default widths, jump-code
// constants and a jump-condition helper.
package hack_pkg;

    // Default widths
    localparam int HACK_WIDTH  = 16;
    localparam int HACK_ADDR_W = 15;

    // Instruction field bit positions
    localparam int INSTR_TYPE = 15;
    localparam int DEST_A     = 5;
    localparam int DEST_D     = 4;
    localparam int DEST_M     = 3;
    localparam int JMP_LT     = 2;
    localparam int JMP_EQ     = 1;
    localparam int JMP_GT     = 0;

    // Jump codes (instr[2:0])
    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    // Each jump bit selects one sign class of the ALU result; "positive"
    // means neither negative nor zero.
    function automatic logic jump_taken(input logic [2:0] jmp,
                                        input logic       zr,
                                        input logic       ng);
        return (jmp[JMP_LT] & ng)
             | (jmp[JMP_EQ] & zr)
             | (jmp[JMP_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - WIDTH-bit program counter with reset/load/increment
//
// Purpose: program counter with priority reset > load > inc; wraps modulo
// 2^WIDTH.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset to zero
//   load     in   load pc from load_val
//   inc      in   increment pc
//   load_val in   WIDTH load value
//   pc       out  WIDTH current count
module program_counter
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/hack_cpu_state_stage.sv
// rtl/hack_cpu_state_stage.sv - Hack CPU A/D register and program counter stage
//
// Purpose: holds A, D and pc; applies the current instruction's destination
// and jump fields using the ALU result and flags.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              advance enable (0 stalls)
//   instruction     current instruction word
//   alu_out/zr/ng   ALU result and flags for this instruction
//   a_out, d_out    A and D registers
//   pc              program counter
//   write_m         data-memory write strobe (combinational)
//   address_m       A[ADDR_W-1:0]
//   out_m           data to memory (alu_out)
module hack_cpu_state_stage
    import hack_pkg::*;
#(
    parameter int WIDTH  = HACK_WIDTH,
    parameter int ADDR_W = HACK_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  instruction,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [WIDTH-1:0]  a_out,
    output logic [WIDTH-1:0]  d_out,
    output logic [WIDTH-1:0]  pc,
    output logic              write_m,
    output logic [ADDR_W-1:0] address_m,
    output logic [WIDTH-1:0]  out_m
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             is_c;
    logic             take_jump;

    // Computation bits (a, c1..c6) are consumed by the ALU, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[WIDTH-2:DEST_A+1];

    assign is_c      = instruction[INSTR_TYPE];
    assign take_jump = is_c & jump_taken(instruction[JMP_LT:JMP_GT], alu_zr, alu_ng);

    always_comb begin
        a_d = a_q;
        d_d = d_q;
        if (en) begin
            if (!is_c) begin
                a_d = instruction;
            end else begin
                if (instruction[DEST_A]) a_d = alu_out;
                if (instruction[DEST_D]) d_d = alu_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a_d;
            d_q <= d_d;
        end
    end

    // Jump target is the pre-edge A, even when d1 rewrites A on this edge.
    program_counter #(.WIDTH(WIDTH)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (en & take_jump),
        .inc      (en & ~take_jump),
        .load_val (a_q),
        .pc       (pc)
    );

    assign write_m   = ~reset & en & is_c & instruction[DEST_M];
    assign address_m = a_q[ADDR_W-1:0];
    assign out_m     = alu_out;
    assign a_out     = a_q;
    assign d_out     = d_q;

endmodule

// File: tb/tb_hack_cpu_state_stage.sv
// tb/tb_hack_cpu_state_stage.sv - self-checking bench for hack_cpu_state_stage
module tb_hack_cpu_state_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] instruction;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_out;
    logic [15:0] d_out;
    logic [15:0] pc;
    logic        write_m;
    logic [14:0] address_m;
    logic [15:0] out_m;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state
    logic [15:0] m_a, m_d, m_pc;

    always #5 clk = ~clk;

    hack_cpu_state_stage dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .instruction (instruction),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .a_out       (a_out),
        .d_out       (d_out),
        .pc          (pc),
        .write_m     (write_m),
        .address_m   (address_m),
        .out_m       (out_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Jump decision from the signed value of the ALU result.
    function automatic bit model_jump(input logic [2:0] code, input logic [15:0] res);
        int v;
        v = $signed(res);
        case (code)
            3'd0: return 1'b0;
            3'd1: return v > 0;
            3'd2: return v == 0;
            3'd3: return v >= 0;
            3'd4: return v < 0;
            3'd5: return v != 0;
            3'd6: return v <= 0;
            default: return 1'b1;
        endcase
    endfunction

    // One instruction: flags derived from the ALU value, combinational outputs
    // checked before the edge, registers checked after it.
    task automatic step(input string tag, input logic rst, input logic e,
                        input logic [15:0] ins, input logic [15:0] alu);
        logic        exp_wm;
        logic [15:0] old_a;
        reset       = rst;
        en          = e;
        instruction = ins;
        alu_out     = alu;
        alu_zr      = (alu == 16'h0000);
        alu_ng      = alu[15];
        #1;
        exp_wm = !rst && e && ins[15] && ins[3];
        check({tag, ".write_m"}, {31'd0, write_m}, {31'd0, exp_wm});
        check({tag, ".address_m"}, {17'd0, address_m}, {17'd0, m_a[14:0]});
        check({tag, ".out_m"}, {16'd0, out_m}, {16'd0, alu});
        @(posedge clk);
        if (rst) begin
            m_a = 0; m_d = 0; m_pc = 0;
        end else if (e) begin
            if (!ins[15]) begin
                m_a  = ins;
                m_pc = m_pc + 16'd1;
            end else begin
                old_a = m_a;
                if (ins[5]) m_a = alu;
                if (ins[4]) m_d = alu;
                m_pc = model_jump(ins[2:0], alu) ? old_a : m_pc + 16'd1;
            end
        end
        #1;
        check({tag, ".a_out"}, {16'd0, a_out}, {16'd0, m_a});
        check({tag, ".d_out"}, {16'd0, d_out}, {16'd0, m_d});
        check({tag, ".pc"}, {16'd0, pc}, {16'd0, m_pc});
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; instruction = 16'h0000;
        alu_out = 16'h0000; alu_zr = 1'b1; alu_ng = 1'b0;
        m_a = 0; m_d = 0; m_pc = 0;
        @(posedge clk);
        #1;

        // Directed cases
        step("reset",     1'b1, 1'b1, 16'h0000, 16'h0000);
        step("ainstr",    1'b0, 1'b1, 16'h1234, 16'h0000);
        check("ainstr.pc_is_1", {16'd0, pc}, 32'h1);
        step("setA10",    1'b0, 1'b1, 16'h0010, 16'h0000);
        step("d_eq_a",    1'b0, 1'b1, 16'hEC10, 16'h0010);
        step("m_eq_d",    1'b0, 1'b1, 16'hE308, 16'h0010);
        step("setA40",    1'b0, 1'b1, 16'h0040, 16'h0000);
        step("jeq_take",  1'b0, 1'b1, 16'hE302, 16'h0000);
        check("jeq_take.pc40", {16'd0, pc}, 32'h40);
        step("jeq_skip",  1'b0, 1'b1, 16'hE302, 16'h0005);
        step("jgt_neg",   1'b0, 1'b1, 16'hE301, 16'h8000);
        step("jlt_neg",   1'b0, 1'b1, 16'hE304, 16'hFFFF);
        step("setA100",   1'b0, 1'b1, 16'h0100, 16'h0000);
        step("a1_jmp",    1'b0, 1'b1, 16'hEFA7, 16'h0001);
        check("a1_jmp.pc100", {16'd0, pc}, 32'h100);
        step("stall",     1'b0, 1'b0, 16'hEFD8, 16'h1111);
        step("setAffff",  1'b0, 1'b1, 16'hEC20, 16'hFFFF);
        step("jmp_ffff",  1'b0, 1'b1, 16'hEA87, 16'h0000);
        step("wrap",      1'b0, 1'b1, 16'h0003, 16'h0000);
        check("wrap.pc0", {16'd0, pc}, 32'h0);
        step("pre_rst",   1'b0, 1'b1, 16'h0077, 16'h0000);
        step("rst_write", 1'b1, 1'b1, 16'hE308, 16'h0042);

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            logic        r, e;
            logic [15:0] ins, alu;
            r   = ($urandom_range(0, 49) == 0);
            e   = ($urandom_range(0, 7) != 0);
            ins = 16'($urandom);
            alu = 16'($urandom);
            if ($urandom_range(0, 5) == 0) alu = 16'h0000;
            if ($urandom_range(0, 3) != 0) ins[15:13] = 3'b111;
            step("rand", r, e, ins, alu);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
